// File: rtl/usb_cmd_pkg.sv
// Shared state encoding, command codes and response codes for the USB command parser.
// Build option USB_CMD_PARSER_CHECKSUM_EN adds the CSUM state for 6-byte frames.
package usb_cmd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DHI,
      ST_DLO,
`ifdef USB_CMD_PARSER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_EXEC,
      ST_WAIT_RD,
      ST_RESP0,
      ST_RESP1,
      ST_RESP2
   } state_e;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   localparam logic [7:0] ACK      = 8'h01;
   localparam logic [7:0] ERR_CMD  = 8'hEE;
   localparam logic [7:0] ERR_TMO  = 8'hE7;
   localparam logic [7:0] ERR_CSUM = 8'hEC;

   // States in which the parser is willing to take a byte from the USB block.
   function automatic logic isRxState(input state_e s);
      logic r;
      r = (s == ST_IDLE) || (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DHI) || (s == ST_DLO);
`ifdef USB_CMD_PARSER_CHECKSUM_EN
      r = r || (s == ST_CSUM);
`endif
      return r;
   endfunction

endpackage

// File: rtl/usb_cmd_timer.sv
// Clearable idle counter for the USB command parser; saturates at TIMEOUT_CYCLES
// and flags the terminal count so the parser can abandon a stalled frame or read.
module usb_cmd_timer #(
   parameter int TMR_W          = 26,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic en_i,
   output logic done_o
);

   localparam logic [TMR_W-1:0] TERMINAL = TMR_W'(TIMEOUT_CYCLES);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !done_o) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/usb_cmd_parser.sv
// Decodes SYNC/CMD/ADDR/DHI/DLO frames from the FX2 byte stream into register-bus strobes and
// streams back a response. Define USB_CMD_PARSER_CHECKSUM_EN for an extra XOR checksum byte.
module usb_cmd_parser
   import usb_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter logic [7:0] RESP_SYNC      = 8'h5A,
   parameter int         TIMEOUT_CYCLES = 50000000,
   parameter int         TMR_W          = 26
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wr,
   output logic        reg_rd,
   input  logic [15:0] reg_rdata,
   input  logic        reg_rd_valid,
   output logic        frame_err
);

   state_e     state_q, state_d;
   logic [7:0] cmd_q, cmd_d, addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
   logic [7:0] code_q, code_d, rdlo_q, rdlo_d;
   logic       has3_q, has3_d, err_q, err_d, rdy_q, rdy_d;
   logic       rxAcc, txAcc, midFrame, tmrDone, csumOk, isWrite, isRead;

   assign rxAcc    = rx_valid && rdy_q;
   assign txAcc    = tx_valid && tx_ready;
   assign midFrame = isRxState(state_q) && (state_q != ST_IDLE);
   assign isWrite  = csumOk && (cmd_q == CMD_WRITE);
   assign isRead   = csumOk && (cmd_q == CMD_READ);

`ifdef USB_CMD_PARSER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   assign csumOk = (csum_q == (cmd_q ^ addr_q ^ dhi_q ^ dlo_q));
`else
   assign csumOk = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      dhi_d   = dhi_q;
      dlo_d   = dlo_q;
      code_d  = code_q;
      rdlo_d  = rdlo_q;
      has3_d  = has3_q;
      err_d   = err_q;
`ifdef USB_CMD_PARSER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         ST_IDLE:    if (rxAcc && rx_data == SYNC_BYTE) state_d = ST_CMD;
         ST_CMD:     if (rxAcc) begin cmd_d  = rx_data; state_d = ST_ADDR; end
         ST_ADDR:    if (rxAcc) begin addr_d = rx_data; state_d = ST_DHI;  end
         ST_DHI:     if (rxAcc) begin dhi_d  = rx_data; state_d = ST_DLO;  end
`ifdef USB_CMD_PARSER_CHECKSUM_EN
         ST_DLO:     if (rxAcc) begin dlo_d  = rx_data; state_d = ST_CSUM; end
         ST_CSUM:    if (rxAcc) begin csum_d = rx_data; state_d = ST_EXEC; end
`else
         ST_DLO:     if (rxAcc) begin dlo_d  = rx_data; state_d = ST_EXEC; end
`endif
         // A checksum failure outranks a bad command code, and neither strobes the bus.
         ST_EXEC: begin
            has3_d = 1'b0;
            if (isRead) begin
               state_d = ST_WAIT_RD;
            end else begin
               state_d = ST_RESP0;
               if (!csumOk) begin
                  code_d = ERR_CSUM;
                  err_d  = 1'b1;
               end else if (isWrite) begin
                  code_d = ACK;
               end else begin
                  code_d = ERR_CMD;
                  err_d  = 1'b1;
               end
            end
         end
         ST_WAIT_RD: begin
            if (reg_rd_valid) begin
               code_d  = reg_rdata[15:8];
               rdlo_d  = reg_rdata[7:0];
               has3_d  = 1'b1;
               state_d = ST_RESP0;
            end else if (tmrDone) begin
               code_d  = ERR_TMO;
               err_d   = 1'b1;
               state_d = ST_RESP0;
            end
         end
         ST_RESP0:   if (txAcc) state_d = ST_RESP1;
         ST_RESP1:   if (txAcc) state_d = has3_q ? ST_RESP2 : ST_IDLE;
         ST_RESP2:   if (txAcc) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      // A byte arriving on the terminal-count cycle still wins, since rx_ready was already offered.
      if (midFrame && !rxAcc && tmrDone) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end
      rdy_d = isRxState(state_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         addr_q  <= '0;
         dhi_q   <= '0;
         dlo_q   <= '0;
         code_q  <= '0;
         rdlo_q  <= '0;
         has3_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef USB_CMD_PARSER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         dhi_q   <= dhi_d;
         dlo_q   <= dlo_d;
         code_q  <= code_d;
         rdlo_q  <= rdlo_d;
         has3_q  <= has3_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
`ifdef USB_CMD_PARSER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   usb_cmd_timer #(
      .TMR_W         (TMR_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .clear_i(rxAcc || (state_d != state_q)),
      .en_i   (midFrame || (state_q == ST_WAIT_RD)),
      .done_o (tmrDone)
   );

   always_comb begin
      case (state_q)
         ST_RESP0: tx_data = RESP_SYNC;
         ST_RESP1: tx_data = code_q;
         ST_RESP2: tx_data = rdlo_q;
         default:  tx_data = 8'h00;
      endcase
   end

   assign rx_ready  = rdy_q;
   assign tx_valid  = (state_q == ST_RESP0) || (state_q == ST_RESP1) || (state_q == ST_RESP2);
   assign reg_wr    = (state_q == ST_EXEC) && isWrite;
   assign reg_rd    = (state_q == ST_EXEC) && isRead;
   assign reg_addr  = addr_q;
   assign reg_wdata = {dhi_q, dlo_q};
   assign frame_err = err_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Self-checking bench for usb_cmd_parser: directed frames followed by randomized frames,
// all checked against a frame-level model of expected strobes, response bytes and error flag.
module tb_usb_cmd_parser;

   localparam int TMO = 100;
`ifdef USB_CMD_PARSER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk          = 1'b0;
   logic        reset_n      = 1'b0;
   logic [7:0]  rx_data      = '0;
   logic        rx_valid     = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready     = 1'b0;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [15:0] reg_rdata    = '0;
   logic        reg_rd_valid = 1'b0;
   logic        frame_err;

   int nComp = 0;
   int nFail = 0;

   int cyc = 0;
   int lastAccCyc = 0;
   int wrCyc = -1;
   int txStartCyc = -1;
   int stabErr = 0;
   logic       held = 1'b0;
   logic       prevTxV = 1'b0;
   logic [7:0] heldData = '0;
   logic [7:0]  gotTx[$];
   logic [31:0] gotStb[$];

   logic [7:0]  expTx[$];
   logic [31:0] expStb[$];
   bit          expErr = 1'b0;
   bit          expWrite = 1'b0;

   bit          bpMode = 1'b0;
   int          stallReq = 0;
   int          stallAck = 0;
   int          stallLeft = 0;
   int          spurReq = 0;
   int          spurAck = 0;
   logic [15:0] rdData = '0;
   int          rdLat = 1;
   bit          rdRespond = 1'b1;

   usb_cmd_parser #(
      .SYNC_BYTE     (8'hA5),
      .RESP_SYNC     (8'h5A),
      .TIMEOUT_CYCLES(TMO),
      .TMR_W         (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_rdata   (reg_rdata),
      .reg_rd_valid(reg_rd_valid),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe the DUT mid-cycle: transferred bytes, strobes, and tx hold stability under backpressure.
   always @(negedge clk) begin
      if (!reset_n) begin
         held    = 1'b0;
         prevTxV = 1'b0;
      end else begin
         if (held && !(tx_valid && tx_data == heldData)) stabErr++;
         held     = tx_valid && !tx_ready;
         heldData = tx_data;
         if (tx_valid && !prevTxV) txStartCyc = cyc;
         prevTxV = tx_valid;
         if (tx_valid && tx_ready) gotTx.push_back(tx_data);
         if (reg_wr) begin
            gotStb.push_back({8'h01, reg_addr, reg_wdata});
            wrCyc = cyc;
         end
         if (reg_rd) gotStb.push_back({8'h02, reg_addr, 16'h0000});
      end
   end

   always @(posedge clk) begin
      #1;
      if (stallAck != stallReq && tx_valid) begin
         stallAck  = stallReq;
         stallLeft = 10;
      end
      if (stallLeft > 0) begin
         tx_ready = 1'b0;
         stallLeft--;
      end else begin
         tx_ready = bpMode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Register-bus slave: answers reads after rdLat cycles, or injects a stray rd_valid on request.
   always @(negedge clk) begin
      if (spurAck != spurReq) begin
         spurAck      = spurReq;
         reg_rdata    = 16'hDEAD;
         reg_rd_valid = 1'b1;
         @(negedge clk);
         reg_rd_valid = 1'b0;
      end else if (reg_rd && rdRespond) begin
         repeat (rdLat) @(negedge clk);
         reg_rdata    = rdData;
         reg_rd_valid = 1'b1;
         @(negedge clk);
         reg_rd_valid = 1'b0;
         reg_rdata    = '0;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nComp++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      int waitCnt;
      waitCnt = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && waitCnt < 500) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!rx_ready) checkOutput("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;
      lastAccCyc = cyc;
      rx_valid   = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] dhi, input logic [7:0] dlo, input bit badCs);
      logic [7:0] cs;
      cs = cmd ^ addr ^ dhi ^ dlo;
      applyStimulus(8'hA5);
      applyStimulus(cmd);
      applyStimulus(addr);
      applyStimulus(dhi);
      applyStimulus(dlo);
      if (CSUM_ON) applyStimulus(badCs ? ~cs : cs);
   endtask

   // Frame-level reference: what the host should see for one complete frame.
   function automatic void buildExpected(input logic [7:0] cmd, input logic [7:0] addr,
                                         input logic [7:0] dhi, input logic [7:0] dlo,
                                         input logic [15:0] rd, input bit respond, input bit badCs);
      expTx.delete();
      expStb.delete();
      expWrite = 1'b0;
      expTx.push_back(8'h5A);
      if (CSUM_ON && badCs) begin
         expTx.push_back(8'hEC);
         expErr = 1'b1;
      end else if (cmd == 8'h01) begin
         expStb.push_back({8'h01, addr, dhi, dlo});
         expTx.push_back(8'h01);
         expWrite = 1'b1;
      end else if (cmd == 8'h02) begin
         expStb.push_back({8'h02, addr, 16'h0000});
         if (respond) begin
            expTx.push_back(rd[15:8]);
            expTx.push_back(rd[7:0]);
         end else begin
            expTx.push_back(8'hE7);
            expErr = 1'b1;
         end
      end else begin
         expTx.push_back(8'hEE);
         expErr = 1'b1;
      end
   endfunction

   task automatic runFrame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] dhi,
                           input logic [7:0] dlo, input logic [15:0] rd, input bit respond,
                           input int lat, input bit badCs, input int garbage);
      int txBase, stbBase, waitCnt;
      logic [7:0] b;
      buildExpected(cmd, addr, dhi, dlo, rd, respond, badCs);
      rdData    = rd;
      rdLat     = lat;
      rdRespond = respond;
      txBase    = gotTx.size();
      stbBase   = gotStb.size();
      for (int i = 0; i < garbage; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h00;
         applyStimulus(b);
      end
      sendFrame(cmd, addr, dhi, dlo, badCs);
      waitCnt = 0;
      while ((gotTx.size() - txBase) < expTx.size() && waitCnt < 2 * TMO + 200) begin
         @(negedge clk);
         waitCnt++;
      end
      repeat (5) @(negedge clk);
      checkOutput("tx_count", 32'(gotTx.size() - txBase), 32'(expTx.size()));
      foreach (expTx[i])
         checkOutput("tx_byte", (txBase + i < gotTx.size()) ? 32'(gotTx[txBase + i]) : 32'hFFFF_FFFF,
                     32'(expTx[i]));
      checkOutput("strobe_count", 32'(gotStb.size() - stbBase), 32'(expStb.size()));
      foreach (expStb[i])
         checkOutput("strobe", (stbBase + i < gotStb.size()) ? gotStb[stbBase + i] : 32'hFFFF_FFFF,
                     expStb[i]);
      if (expWrite) begin
         checkOutput("wr_latency", 32'(wrCyc), 32'(lastAccCyc));
         checkOutput("resp0_latency", 32'(txStartCyc), 32'(wrCyc + 1));
      end
      checkOutput("frame_err", 32'(frame_err), 32'(expErr));
      checkOutput("tx_hold_stable", 32'(stabErr), 32'd0);
      checkOutput("idle_tx_valid", 32'(tx_valid), 32'd0);
   endtask

   initial begin
      int txB, stbB, w, r;
      logic [7:0] c;

      repeat (3) @(negedge clk);
      checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
      checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_reg_wr", 32'(reg_wr), 32'd0);
      checkOutput("rst_reg_rd", 32'(reg_rd), 32'd0);
      checkOutput("rst_reg_addr", 32'(reg_addr), 32'd0);
      checkOutput("rst_reg_wdata", 32'(reg_wdata), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_rx_ready", 32'(rx_ready), 32'd1);

      $display("[TB] directed write and read");
      runFrame(8'h01, 8'h10, 8'h12, 8'h34, 16'h0000, 1'b1, 1, 1'b0, 0);
      runFrame(8'h02, 8'h20, 8'h00, 8'h00, 16'hBEEF, 1'b1, 3, 1'b0, 0);

      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      applyStimulus(8'h13);
      runFrame(8'h01, 8'h3C, 8'h56, 8'h78, 16'h0000, 1'b1, 1, 1'b0, 0);
      runFrame(8'h01, 8'hA5, 8'hA5, 8'hA5, 16'h0000, 1'b1, 1, 1'b0, 0);

      stallReq++;
      runFrame(8'h02, 8'h44, 8'h00, 8'h00, 16'hC0DE, 1'b1, 5, 1'b0, 0);

      txB = gotTx.size();
      spurReq++;
      repeat (6) @(negedge clk);
      checkOutput("spur_no_tx", 32'(gotTx.size() - txB), 32'd0);
      checkOutput("spur_tx_valid", 32'(tx_valid), 32'd0);

      runFrame(8'h01, 8'h10, 8'h12, 8'h34, 16'h0000, 1'b1, 1, 1'b1, 0);

      $display("[TB] error cases");
      txB  = gotTx.size();
      stbB = gotStb.size();
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h10);
      repeat (TMO + 20) @(negedge clk);
      expErr = 1'b1;
      checkOutput("stall_frame_err", 32'(frame_err), 32'd1);
      checkOutput("stall_no_tx", 32'(gotTx.size() - txB), 32'd0);
      checkOutput("stall_no_strobe", 32'(gotStb.size() - stbB), 32'd0);
      runFrame(8'h01, 8'h61, 8'h9A, 8'hBC, 16'h0000, 1'b1, 1, 1'b0, 0);

      runFrame(8'h07, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1, 1'b0, 0);
      runFrame(8'h02, 8'h30, 8'h00, 8'h00, 16'h0000, 1'b0, 1, 1'b0, 0);

      stallReq++;
      sendFrame(8'h01, 8'h55, 8'h66, 8'h77, 1'b0);
      w = 0;
      while (!tx_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!tx_valid) checkOutput("resp_start", 32'(tx_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("midrst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("midrst_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      expErr  = 1'b0;
      @(negedge clk);
      runFrame(8'h01, 8'h77, 8'h01, 8'h02, 16'h0000, 1'b1, 1, 1'b0, 0);

      $display("[TB] randomized frames");
      bpMode = 1'b1;
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      c = 8'h01;
         else if (r < 8) c = 8'h02;
         else            c = 8'($urandom_range(3, 255));
         runFrame(c, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 9) != 0, $urandom_range(1, 20),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
      $finish;
   end

endmodule

// File: doc/usb_cmd_parser.md
Name: usb_cmd_parser

Overview:
- Sits directly downstream of the FX2 USB slave-FIFO block (usb_top) on the Nexys2 board.
- Consumes its received byte stream and decodes fixed-format command frames into single-cycle register-bus reads and writes.
- Returns a response byte stream to the USB block for transmission to the host.
- Gives the host PC register access to the rest of the FPGA design.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every command frame.
- RESP_SYNC, 8'h5A, first byte of every response.
- TIMEOUT_CYCLES, 50000000, maximum idle cycles mid-frame or while waiting for read data (1 s at 50 MHz).
- TMR_W, 26, timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz clk0 domain)
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from USB block
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  parser accepts rx_data this cycle
- tx_data  out  8  response byte to USB block
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  USB block accepts tx_data this cycle
- reg_addr  out  8  register address
- reg_wdata  out  16  register write data
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  16  read data
- reg_rd_valid  in  1  reg_rdata valid, one or more cycles after reg_rd
- frame_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset: one clock; reset_n is asynchronous, active-low. All outputs 0; state IDLE; timer 0.
- Byte transfer:
  - A byte moves when valid && ready on the same rising edge.
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid is never deasserted before acceptance.
- Frame format: SYNC, CMD, ADDR, DHI, DLO.
  - CMD 8'h01 = write; CMD 8'h02 = read; DHI/DLO are ignored for reads.
- States: IDLE, CMD, ADDR, DHI, DLO, EXEC, WAIT_RD, RESP0, RESP1, RESP2.
- rx_ready: 1 in IDLE, CMD, ADDR, DHI, DLO; 0 in all other states.
- IDLE: discard bytes until rx_data == SYNC_BYTE, then go to CMD. Non-sync bytes are consumed silently.
- CMD/ADDR/DHI/DLO: each latches its byte and advances on acceptance.
  - After DLO: go to EXEC.
  - Bad CMD value: the frame is still fully consumed, then the error response is sent.
- EXEC (one cycle):
  - Write: reg_wr=1 with reg_addr = ADDR and reg_wdata = {DHI,DLO}, then go to RESP0.
  - Read: reg_rd=1, then go to WAIT_RD.
  - Bad CMD: no strobe; go to RESP0.
- WAIT_RD: capture reg_rdata when reg_rd_valid, then go to RESP0. A reg_rd_valid outside WAIT_RD is ignored.
- Responses (RESP0 sends RESP_SYNC):
  - Write: RESP_SYNC, 8'h01.
  - Read: RESP_SYNC, DHI_rd, DLO_rd.
  - Bad CMD: RESP_SYNC, 8'hEE.
  - Read timeout: RESP_SYNC, 8'hE7.
  - After the last byte is accepted: go to IDLE.
- Timeout:
  - The timer clears on every accepted rx byte and on every state change.
  - It counts in CMD..DLO and WAIT_RD.
  - When it reaches TIMEOUT_CYCLES mid-frame: go to IDLE, set frame_err, no response.
  - When it reaches TIMEOUT_CYCLES in WAIT_RD: send the E7 response and set frame_err.
- Bad CMD also sets frame_err.
- SYNC_BYTE appearing mid-frame is treated as ordinary data (no resync).
- Latency: the reg_wr strobe occurs exactly 1 cycle after DLO acceptance. RESP0 tx_valid rises the cycle after EXEC for writes.
- Reset asserted mid-frame or mid-response: immediate return to IDLE; partial response abandoned.

Optional Feature:
- Macro USB_CMD_PARSER_CHECKSUM_EN.
- When defined:
  - Adds state CSUM after DLO; frame gains a 6th byte equal to XOR of CMD, ADDR, DHI, DLO.
  - On mismatch: no reg strobe, response RESP_SYNC, 8'hEC, frame_err set.
  - CSUM is included in timeout handling.
- When undefined: 5-byte frames, no CSUM state, no checksum logic.

Decomposition:
- Package usb_cmd_pkg:
  - State enum.
  - CMD_WRITE/CMD_READ codes.
  - Response codes ACK 8'h01, ERR_CMD 8'hEE, ERR_TMO 8'hE7, ERR_CSUM 8'hEC.
- Sub-module usb_cmd_timer: a TMR_W-bit clearable counter with a terminal-count output, instanced once.

Test Plan:
- Write frame A5 01 10 12 34 -> one-cycle reg_wr with reg_addr=10, reg_wdata=1234 one cycle after the last byte; tx bytes 5A 01.
- Read frame A5 02 20 00 00; reg_rd_valid 3 cycles after reg_rd with rdata=BEEF -> tx 5A BE EF.
- Garbage 00 FF 13 preceding a write frame -> garbage consumed silently; single correct write occurs.
- Bad CMD A5 07 00 00 00 -> no strobes; tx 5A EE; frame_err=1.
- tx_ready low for 10 cycles during response; separately, frame stalled after ADDR for TIMEOUT_CYCLES -> tx bytes held stable, no loss or duplication; stalled frame returns to IDLE with frame_err=1 and no tx.
- With USB_CMD_PARSER_CHECKSUM_EN: A5 01 10 12 34 37 -> write and 5A 01; checksum 00 -> 5A EC, no reg_wr.
